// File: rtl/mp64_extmem_arb_pkg.sv
// Shared definitions for the Megapad-64 external-memory PHY port and its arbiter.
package mp64_extmem_arb_pkg;
   localparam int MP64_PHY_AW  = 24;
   localparam int MP64_PHY_DW  = 64;
   localparam int MP64_PHY_BLW = 4;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2
   } arb_state_t;
endpackage

// File: rtl/mp64_rr_pick.sv
// Rotating priority encoder: first asserted request searching upward from ptr+1.
module mp64_rr_pick #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      ptr,
   output logic [1:0]      grant,
   output logic            any
);
   always_comb begin
      grant = 2'd0;
      any   = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!any && req[i] && (i == (int'(ptr) + k) % NREQ)) begin
               grant = 2'(i);
               any   = 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/mp64_extmem_arb.sv
// Round-robin arbiter and command sequencer for the shared external-memory PHY,
// with a watchdog that aborts a transaction when the PHY never returns ready.
//
// state     | meaning
// ARB_IDLE  | waiting for phy_ready and a request; latches the winner's command
// ARB_ISSUE | one-cycle PHY strobe and accept pulse to the owner
// ARB_WAIT  | routing read beats; leaves on phy_ready or watchdog expiry
module mp64_extmem_arb
   import mp64_extmem_arb_pkg::*;
#(
   parameter int NREQ        = 2,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CW          = 11
) (
   input  logic                         sys_clk,
   input  logic                         sys_rst_n,
   input  logic [NREQ-1:0]              req_valid,
   input  logic [NREQ*MP64_PHY_AW-1:0]  req_addr,
   input  logic [NREQ-1:0]              req_wen,
   input  logic [NREQ*MP64_PHY_DW-1:0]  req_wdata,
   input  logic [NREQ*MP64_PHY_BLW-1:0] req_burst,
   output logic [NREQ-1:0]              req_accept,
   output logic [NREQ-1:0]              req_rvalid,
   output logic [MP64_PHY_DW-1:0]       req_rdata,
   output logic [NREQ-1:0]              req_done,
   output logic                         req_err,
   output logic                         phy_req,
   output logic [MP64_PHY_AW-1:0]       phy_addr,
   output logic                         phy_wen,
   output logic [MP64_PHY_DW-1:0]       phy_wdata,
   output logic [MP64_PHY_BLW-1:0]      phy_burst_len,
   input  logic [MP64_PHY_DW-1:0]       phy_rdata,
   input  logic                         phy_rvalid,
   input  logic                         phy_ready,
   output logic                         busy,
   output logic [1:0]                   owner,
   output logic                         timeout_sticky,
   input  logic                         timeout_clr
);
   arb_state_t state, state_nxt;

   logic [1:0]              ptr;
   logic [1:0]              gnt;
   logic                    gnt_any;
   logic [CW-1:0]           wdog;
   logic                    wdog_hit;
   logic                    done_to;
   logic [MP64_PHY_AW-1:0]  sel_addr;
   logic                    sel_wen;
   logic [MP64_PHY_DW-1:0]  sel_wdata;
   logic [MP64_PHY_BLW-1:0] sel_burst;

   mp64_rr_pick #(.NREQ(NREQ)) u_pick (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (gnt),
      .any   (gnt_any)
   );

   always_comb begin
      sel_addr  = '0;
      sel_wen   = 1'b0;
      sel_wdata = '0;
      sel_burst = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt == 2'(i)) begin
            sel_addr  = req_addr[i*MP64_PHY_AW +: MP64_PHY_AW];
            sel_wen   = req_wen[i];
            sel_wdata = req_wdata[i*MP64_PHY_DW +: MP64_PHY_DW];
            sel_burst = req_burst[i*MP64_PHY_BLW +: MP64_PHY_BLW];
         end
      end
   end

   assign wdog_hit = (wdog == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= ARB_IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE:  if (phy_ready && gnt_any) state_nxt = ARB_ISSUE;
         ARB_ISSUE: state_nxt = ARB_WAIT;
         ARB_WAIT:  if (phy_ready || wdog_hit) state_nxt = ARB_IDLE;
         default:   state_nxt = ARB_IDLE;
      endcase
   end

   always_comb begin
      phy_req    = 1'b0;
      busy       = 1'b0;
      req_accept = '0;
      req_rvalid = '0;
      req_done   = '0;
      req_rdata  = '0;
      req_err    = 1'b0;
      done_to    = 1'b0;
      case (state)
         ARB_ISSUE: begin
            phy_req = 1'b1;
            busy    = 1'b1;
            for (int i = 0; i < NREQ; i++) req_accept[i] = (owner == 2'(i));
         end
         ARB_WAIT: begin
            busy    = 1'b1;
            done_to = wdog_hit && !phy_ready;
            req_err = done_to;
            for (int i = 0; i < NREQ; i++) begin
               req_rvalid[i] = phy_rvalid && (owner == 2'(i));
               req_done[i]   = (phy_ready || wdog_hit) && (owner == 2'(i));
            end
            if (phy_rvalid) req_rdata = phy_rdata;
         end
         default: ;
      endcase
   end

   // Command fields are captured at grant and held until the next grant.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ptr            <= 2'(NREQ - 1);
         owner          <= 2'd0;
         wdog           <= '0;
         phy_addr       <= '0;
         phy_wen        <= 1'b0;
         phy_wdata      <= '0;
         phy_burst_len  <= '0;
         timeout_sticky <= 1'b0;
      end else begin
         if (state == ARB_IDLE && phy_ready && gnt_any) begin
            owner         <= gnt;
            phy_addr      <= sel_addr;
            phy_wen       <= sel_wen;
            phy_wdata     <= sel_wdata;
            phy_burst_len <= sel_wen ? '0 : sel_burst;
         end
         if (state == ARB_ISSUE) begin
            ptr  <= owner;
            wdog <= '0;
         end else if (state == ARB_WAIT) begin
            wdog <= wdog + CW'(1);
         end
         if (done_to)          timeout_sticky <= 1'b1;
         else if (timeout_clr) timeout_sticky <= 1'b0;
      end
   end
endmodule
